// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: per-core request FIFOs arbitrated onto one memory port, responses routed back by core_id.
// Define MEM_REQ_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
package mem_req_arbiter_pkg;
  typedef enum logic [1:0] {READ_REQ, WRITE_REQ, READ_RSP, WRITE_RSP} req_type_t;
  typedef struct packed {
    logic        vld;
    req_type_t   typ;
    logic [3:0]  core_id;
    logic [7:0]  access_id;
    logic [31:0] addr;
    logic [31:0] data;
  } request_t;
endpackage

module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int NUM_CORES  = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic     clk,
  input  logic     reset,
  input  request_t core_req     [NUM_CORES],
  output logic     core_req_rdy [NUM_CORES],
  output request_t core_rsp     [NUM_CORES],
  output request_t mem_req,
  input  request_t mem_rsp,
  output logic     rsp_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(NUM_CORES);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [4:0] NC = 5'(NUM_CORES);
  request_t fifo_mem [NUM_CORES][FIFO_DEPTH];
  logic [AW-1:0] wr_ptr [NUM_CORES];
  logic [AW-1:0] rd_ptr [NUM_CORES];
  logic [AW:0] cnt [NUM_CORES];
  logic push [NUM_CORES];
  logic pop [NUM_CORES];
  logic found;
  logic [CW-1:0] win;
`ifndef MEM_REQ_ARB_FIXED_PRIO_EN
  logic [CW-1:0] ptr;
`endif
  // Scanning in reverse lets the last hit be the first in search order.
  always_comb begin
    found = 1'b0;
    win = '0;
`ifdef MEM_REQ_ARB_FIXED_PRIO_EN
    for (int i = NUM_CORES - 1; i >= 0; i--)
      if (cnt[i] != '0) begin
        found = 1'b1;
        win = CW'(i);
      end
`else
    for (int k = NUM_CORES; k >= 1; k--)
      if (cnt[(int'(ptr) + k) % NUM_CORES] != '0) begin
        found = 1'b1;
        win = CW'((int'(ptr) + k) % NUM_CORES);
      end
`endif
    for (int i = 0; i < NUM_CORES; i++) begin
      core_req_rdy[i] = cnt[i] != FULL;
      push[i] = core_req[i].vld && core_req_rdy[i];
      pop[i] = found && win == CW'(i);
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CORES; i++)
      if (push[i]) fifo_mem[i][wr_ptr[i]] <= core_req[i];
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i]) rd_ptr[i] <= rd_ptr[i] + 1'b1;
        cnt[i] <= cnt[i] + (AW+1)'(push[i]) - (AW+1)'(pop[i]);
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_req <= '0;
      rsp_err <= 1'b0;
`ifndef MEM_REQ_ARB_FIXED_PRIO_EN
      ptr <= CW'(NUM_CORES - 1);
`endif
      for (int j = 0; j < NUM_CORES; j++) core_rsp[j] <= '0;
    end else begin
      if (found) begin
        mem_req <= fifo_mem[win][rd_ptr[win]];
        mem_req.vld <= 1'b1;
        mem_req.core_id <= 4'(win);
`ifndef MEM_REQ_ARB_FIXED_PRIO_EN
        ptr <= win;
`endif
      end else begin
        mem_req.vld <= 1'b0;
      end
      for (int j = 0; j < NUM_CORES; j++) begin
        core_rsp[j].vld <= 1'b0;
        if (mem_rsp.vld && mem_rsp.core_id == 4'(j)) core_rsp[j] <= mem_rsp;
      end
      if (mem_rsp.vld && {1'b0, mem_rsp.core_id} >= NC) rsp_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter: randomized traffic against a queue-based reference model, scoreboard-checked grants and responses.
module tb_mem_req_arbiter;
  import mem_req_arbiter_pkg::*;
  localparam int NC = 4;
  localparam int DEPTH = 2;
  logic clk = 1'b0;
  logic reset = 1'b0;
  request_t core_req [NC];
  logic core_req_rdy [NC];
  request_t core_rsp [NC];
  request_t mem_req;
  request_t mem_rsp = '0;
  logic rsp_err;

  mem_req_arbiter #(.NUM_CORES(NC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .core_req(core_req), .core_req_rdy(core_req_rdy),
    .core_rsp(core_rsp), .mem_req(mem_req), .mem_rsp(mem_rsp), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct { request_t r; int due; } exp_t;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  request_t src_q [NC][$];
  request_t mq [NC][$];
  exp_t sb [NC][$];
  request_t pend [NC];
  bit pend_v [NC];
  bit took [NC];
  request_t last_rsp [NC];
  request_t s1 = '0, s2 = '0, er;
  exp_t ee;
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] ctl_mem [logic [31:0]];
  bit err_exp, log_en, due, mrdy;
  int last = NC - 1;
  int w, inj_req = 0, inj_done = 0;
  int gseq[$], gcyc[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Controller behaviour: writes store data, reads return the last written value (0 if never written).
  function automatic request_t mk_rsp(input request_t r, input bit side);
    request_t o = r;
    o.vld = 1'b1;
    if (r.typ == WRITE_REQ) begin
      o.typ = WRITE_RSP;
      if (side) ref_mem[r.addr] = r.data; else ctl_mem[r.addr] = r.data;
    end else begin
      o.typ = READ_RSP;
      if (side) o.data = ref_mem.exists(r.addr) ? ref_mem[r.addr] : 32'h0;
      else o.data = ctl_mem.exists(r.addr) ? ctl_mem[r.addr] : 32'h0;
    end
    return o;
  endfunction

  function automatic request_t mk_req(input req_type_t t, input logic [31:0] a, input logic [31:0] d, input logic [7:0] id);
    request_t r = '0;
    r.vld = 1'b1;
    r.typ = t;
    r.addr = a;
    r.data = d;
    r.access_id = id;
    r.core_id = 4'($urandom);
    return r;
  endfunction

  // Model, scoreboard monitor and memory controller, all sampled mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      chk("rst mem_req", mem_req, '0);
      chk("rst rsp_err", rsp_err, 0);
      for (int j = 0; j < NC; j++) begin
        chk($sformatf("rst rdy[%0d]", j), core_req_rdy[j], 1);
        chk($sformatf("rst core_rsp[%0d]", j), core_rsp[j], '0);
        mq[j].delete();
        sb[j].delete();
        pend_v[j] = 1'b0;
        took[j] = 1'b0;
      end
      s1 = '0;
      s2 = '0;
      mem_rsp = '0;
      err_exp = 1'b0;
      last = NC - 1;
    end else begin
      if (mem_rsp.vld && mem_rsp.core_id >= NC) err_exp = 1'b1;
      chk("rsp_err", rsp_err, err_exp);
      w = -1;
`ifdef MEM_REQ_ARB_FIXED_PRIO_EN
      for (int c = NC - 1; c >= 0; c--) if (mq[c].size() > 0) w = c;
`else
      for (int k = NC; k >= 1; k--) if (mq[(last + k) % NC].size() > 0) w = (last + k) % NC;
`endif
      if (w >= 0) begin
        er = mq[w].pop_front();
        er.core_id = 4'(w);
        chk("mem_req", mem_req, er);
        ee.r = mk_rsp(er, 1'b1);
        ee.due = cyc + 3;
        sb[w].push_back(ee);
        last = w;
        if (log_en) begin
          gseq.push_back(int'(mem_req.core_id));
          gcyc.push_back(cyc);
        end
      end else begin
        chk("mem_req idle", mem_req.vld, 0);
      end
      for (int j = 0; j < NC; j++) begin
        due = sb[j].size() > 0 && sb[j][0].due == cyc;
        chk($sformatf("core_rsp[%0d].vld", j), core_rsp[j].vld, due);
        if (core_rsp[j].vld) last_rsp[j] = core_rsp[j];
        if (due) begin
          ee = sb[j].pop_front();
          if (core_rsp[j].vld) chk($sformatf("core_rsp[%0d]", j), core_rsp[j], ee.r);
        end
      end
      for (int j = 0; j < NC; j++) begin
        if (pend_v[j]) mq[j].push_back(pend[j]);
        mrdy = mq[j].size() < DEPTH;
        chk($sformatf("rdy[%0d]", j), core_req_rdy[j], mrdy);
        took[j] = core_req[j].vld && mrdy;
        pend_v[j] = took[j];
        pend[j] = core_req[j];
      end
      mem_rsp = s2;
      s2 = s1;
      s1 = mem_req.vld ? mk_rsp(mem_req, 1'b0) : '0;
      if (inj_req != inj_done && !mem_rsp.vld) begin
        mem_rsp = '0;
        mem_rsp.vld = 1'b1;
        mem_rsp.typ = READ_RSP;
        mem_rsp.core_id = 4'd7;
        inj_done++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    for (int j = 0; j < NC; j++) begin
      if (took[j] && src_q[j].size() > 0) void'(src_q[j].pop_front());
      core_req[j] = (reset && src_q[j].size() > 0) ? src_q[j][0] : '0;
    end
  endtask

  task automatic random_traffic(input int n);
    for (int c = 0; c < n; c++) begin
      tick();
      for (int j = 0; j < NC; j++)
        if ($urandom_range(0, j + 1) == 0 && src_q[j].size() < 3)
          src_q[j].push_back(mk_req($urandom_range(0, 1) ? WRITE_REQ : READ_REQ,
                                    32'($urandom_range(0, 15)), $urandom, 8'($urandom)));
    end
  endtask

  initial begin
    for (int j = 0; j < NC; j++) core_req[j] = '0;
    repeat (3) tick();
    #2 reset = 1'b1;
    src_q[2].push_back(mk_req(WRITE_REQ, 32'h10, 32'hA5, 8'd1));
    tick();
    src_q[2].push_back(mk_req(READ_REQ, 32'h10, 32'h0, 8'd2));
    src_q[2][$].core_id = 4'd0;
    repeat (12) tick();
    chk("single read typ", last_rsp[2].typ, READ_RSP);
    chk("single read data", last_rsp[2].data, 32'hA5);
    chk("single read core_id", last_rsp[2].core_id, 4'd2);
    src_q[3].push_back(mk_req(WRITE_REQ, 32'h20, 32'h5A5A1234, 8'd3));
    src_q[3].push_back(mk_req(READ_REQ, 32'h20, 32'h0, 8'd4));
    repeat (12) tick();
    chk("mixed read typ", last_rsp[3].typ, READ_RSP);
    chk("mixed read data", last_rsp[3].data, 32'h5A5A1234);
    log_en = 1'b1;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < NC; j++) src_q[j].push_back(mk_req(READ_REQ, 32'(j), 32'h0, 8'(16 * j + i)));
    repeat (25) tick();
    log_en = 1'b0;
    chk("grant count", gseq.size(), 12);
    for (int i = 0; i < 12 && i < gseq.size(); i++) begin
`ifdef MEM_REQ_ARB_FIXED_PRIO_EN
      chk($sformatf("grant seq[%0d]", i), gseq[i], i / 3);
`else
      chk($sformatf("grant seq[%0d]", i), gseq[i], i % NC);
`endif
      chk($sformatf("grant gap[%0d]", i), gcyc[i] - gcyc[0], i);
    end
    inj_req++;
    repeat (4) tick();
    chk("rsp_err set", rsp_err, 1);
    random_traffic(300);
    chk("rsp_err sticky", rsp_err, 1);
    #2 reset = 1'b0;
    for (int j = 0; j < NC; j++) src_q[j].delete();
    repeat (3) tick();
    #2 reset = 1'b1;
    random_traffic(300);
    repeat (20) tick();
    for (int j = 0; j < NC; j++) begin
      chk($sformatf("drain sb[%0d]", j), sb[j].size(), 0);
      chk($sformatf("drain mq[%0d]", j), mq[j].size(), 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
